// File: rtl/decode_stage_if.sv
// Bundle of fetch, register-file, write-back and execute signals around the decode stage.
// master drives instruction/rf/wb inputs and consumes the execute bundle; slave is the stage.
interface decode_stage_if #(
    parameter int unsigned XLEN = 32
);
    logic            if_valid;
    logic            if_ready;
    logic [31:0]     if_instr;
    logic [XLEN-1:0] if_pc;

    logic [4:0]      rf_read1_id;
    logic [4:0]      rf_read2_id;
    logic [XLEN-1:0] rf_read1_data;
    logic [XLEN-1:0] rf_read2_data;

    logic            wb_en;
    logic [4:0]      wb_id;
    logic [XLEN-1:0] wb_data;

    logic            flush;

    logic            ex_valid;
    logic            ex_ready;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_rs1_data;
    logic [XLEN-1:0] ex_rs2_data;
    logic [XLEN-1:0] ex_imm;
    logic [4:0]      ex_rd;
    logic            ex_rd_we;
    logic [6:0]      ex_opcode;
    logic [2:0]      ex_funct3;
    logic            ex_funct7b5;
    logic            ex_illegal;

    modport master (
        output if_valid, if_instr, if_pc, rf_read1_data, rf_read2_data,
               wb_en, wb_id, wb_data, flush, ex_ready,
        input  if_ready, rf_read1_id, rf_read2_id, ex_valid, ex_pc, ex_rs1_data,
               ex_rs2_data, ex_imm, ex_rd, ex_rd_we, ex_opcode, ex_funct3,
               ex_funct7b5, ex_illegal
    );

    modport slave (
        input  if_valid, if_instr, if_pc, rf_read1_data, rf_read2_data,
               wb_en, wb_id, wb_data, flush, ex_ready,
        output if_ready, rf_read1_id, rf_read2_id, ex_valid, ex_pc, ex_rs1_data,
               ex_rs2_data, ex_imm, ex_rd, ex_rd_we, ex_opcode, ex_funct3,
               ex_funct7b5, ex_illegal
    );
endinterface

// File: rtl/decode_stage.sv
// RV32I decode/operand-fetch stage: decode, write-back bypass, pending-write scoreboard
// for RAW/WAW stalls, and a registered bundle to execute over valid/ready.
module decode_stage #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned NREGS = 32
) (
    input logic           clk,
    input logic           rst_n,
    decode_stage_if.slave bus
);
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpImm    = 7'b0010011;
    localparam logic [6:0] OpReg    = 7'b0110011;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;

    assign instr  = bus.if_instr;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    assign bus.rf_read1_id = rs1;
    assign bus.rf_read2_id = rs2;

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'h000};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    logic            use_rs1;
    logic            use_rs2;
    logic            writes;
    logic            illegal;
    logic [31:0]     imm32;
    logic [XLEN-1:0] imm;
    logic            rd_we;

    always_comb begin
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        writes  = 1'b0;
        illegal = 1'b0;
        imm32   = 32'h0;
        case (opcode)
            OpLui, OpAuipc: begin
                writes = 1'b1;
                imm32  = imm_u;
            end
            OpJal: begin
                writes = 1'b1;
                imm32  = imm_j;
            end
            OpJalr, OpLoad, OpImm: begin
                writes  = 1'b1;
                use_rs1 = 1'b1;
                imm32   = imm_i;
            end
            OpBranch: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = imm_b;
            end
            OpStore: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                imm32   = imm_s;
            end
            OpReg: begin
                writes  = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

    assign rd_we = writes && (rd != 5'd0);
    assign imm   = XLEN'($signed(imm32));

    // Operand select: x0 is hard zero, a same-cycle write-back beats the stale rf read.
    function automatic logic [XLEN-1:0] fetch_operand(
        input logic [4:0]      id,
        input logic [XLEN-1:0] rf_data,
        input logic            wb_en,
        input logic [4:0]      wb_id,
        input logic [XLEN-1:0] wb_data
    );
        if (id == 5'd0) begin
            return '0;
        end else if (wb_en && (wb_id == id)) begin
            return wb_data;
        end
        return rf_data;
    endfunction

    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;

    assign rs1_data = fetch_operand(rs1, bus.rf_read1_data, bus.wb_en, bus.wb_id, bus.wb_data);
    assign rs2_data = fetch_operand(rs2, bus.rf_read2_data, bus.wb_en, bus.wb_id, bus.wb_data);

    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic [NREGS-1:0] wb_onehot;
    logic [NREGS-1:0] busy;

    logic            ex_valid_q;
    logic [XLEN-1:0] ex_pc_q;
    logic [XLEN-1:0] ex_rs1_data_q;
    logic [XLEN-1:0] ex_rs2_data_q;
    logic [XLEN-1:0] ex_imm_q;
    logic [4:0]      ex_rd_q;
    logic            ex_rd_we_q;
    logic [6:0]      ex_opcode_q;
    logic [2:0]      ex_funct3_q;
    logic            ex_funct7b5_q;
    logic            ex_illegal_q;

    // A register being written back this cycle no longer blocks a reader.
    assign wb_onehot = bus.wb_en ? (NREGS'(1) << bus.wb_id) : '0;
    assign busy      = pending_q & ~wb_onehot;

    logic hazard;
    logic if_ready;
    logic issue;
    logic kill_held;

    assign hazard = (use_rs1 && busy[rs1]) || (use_rs2 && busy[rs2]) || (rd_we && busy[rd]);
    assign if_ready = (!ex_valid_q || bus.ex_ready) && !hazard && !bus.flush;
    assign issue    = bus.if_valid && if_ready;
    // A held, undelivered writer that gets flushed will never write back.
    assign kill_held = bus.flush && ex_valid_q && !bus.ex_ready && ex_rd_we_q;

    assign bus.if_ready = if_ready;

    always_comb begin
        pending_d = pending_q;
        if (bus.wb_en) begin
            pending_d[bus.wb_id] = 1'b0;
        end
        if (kill_held) begin
            pending_d[ex_rd_q] = 1'b0;
        end
        if (issue && rd_we) begin
            pending_d[rd] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q    <= 1'b0;
            ex_pc_q       <= '0;
            ex_rs1_data_q <= '0;
            ex_rs2_data_q <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= 5'd0;
            ex_rd_we_q    <= 1'b0;
            ex_opcode_q   <= 7'd0;
            ex_funct3_q   <= 3'd0;
            ex_funct7b5_q <= 1'b0;
            ex_illegal_q  <= 1'b0;
        end else if (issue) begin
            ex_valid_q    <= 1'b1;
            ex_pc_q       <= bus.if_pc;
            ex_rs1_data_q <= rs1_data;
            ex_rs2_data_q <= rs2_data;
            ex_imm_q      <= imm;
            ex_rd_q       <= rd;
            ex_rd_we_q    <= rd_we;
            ex_opcode_q   <= opcode;
            ex_funct3_q   <= instr[14:12];
            ex_funct7b5_q <= instr[30];
            ex_illegal_q  <= illegal;
        end else if (bus.ex_ready || bus.flush) begin
            ex_valid_q <= 1'b0;
        end
    end

    assign bus.ex_valid    = ex_valid_q;
    assign bus.ex_pc       = ex_pc_q;
    assign bus.ex_rs1_data = ex_rs1_data_q;
    assign bus.ex_rs2_data = ex_rs2_data_q;
    assign bus.ex_imm      = ex_imm_q;
    assign bus.ex_rd       = ex_rd_q;
    assign bus.ex_rd_we    = ex_rd_we_q;
    assign bus.ex_opcode   = ex_opcode_q;
    assign bus.ex_funct3   = ex_funct3_q;
    assign bus.ex_funct7b5 = ex_funct7b5_q;
    assign bus.ex_illegal  = ex_illegal_q;
endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios then random traffic, both checked against a
// behavioural model of decode, bypass and the pending-write scoreboard.
module tb_decode_stage;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    decode_stage_if #(.XLEN(32)) bus ();

    decode_stage #(.XLEN(32), .NREGS(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        we;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic        f7;
        logic        ill;
    } bundle_t;

    typedef struct packed {
        logic        u1;
        logic        u2;
        logic        we;
        logic        ill;
        logic [31:0] imm;
    } dec_t;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] rf [32];
    logic [31:0] m_pend;
    bundle_t     m_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the ISA tables, immediates by signed arithmetic.
    function automatic dec_t ref_dec(input logic [31:0] i);
        dec_t d;
        int   v;
        d = '0;
        case (i[6:0])
            7'h37, 7'h17: begin d.we = 1; d.imm = {i[31:12], 12'h000}; end
            7'h6F: begin
                d.we = 1;
                v = int'($signed({i[31], i[19:12], i[20], i[30:21]})) * 2;
                d.imm = 32'(v);
            end
            7'h67, 7'h03, 7'h13: begin
                d.we = 1; d.u1 = 1;
                v = int'($signed(i[31:20]));
                d.imm = 32'(v);
            end
            7'h63: begin
                d.u1 = 1; d.u2 = 1;
                v = int'($signed({i[31], i[7], i[30:25], i[11:8]})) * 2;
                d.imm = 32'(v);
            end
            7'h23: begin
                d.u1 = 1; d.u2 = 1;
                v = int'($signed({i[31:25], i[11:7]}));
                d.imm = 32'(v);
            end
            7'h33: begin d.we = 1; d.u1 = 1; d.u2 = 1; end
            default: d.ill = 1;
        endcase
        if (i[11:7] == 5'd0) d.we = 0;
        return d;
    endfunction

    function automatic bit busy_ref(input logic [4:0] r, input bit wbe, input logic [4:0] wbi);
        return m_pend[r] && !(wbe && wbi == r);
    endfunction

    function automatic logic [31:0] opnd_ref(input logic [4:0] id, input bit wbe,
                                             input logic [4:0] wbi, input logic [31:0] wbd);
        if (id == 5'd0) return 32'h0;
        if (wbe && wbi == id) return wbd;
        return rf[id];
    endfunction

    function automatic logic [31:0] addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'h13};
    endfunction

    function automatic logic [31:0] add(input int rd, input int rs1, input int rs2);
        return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] lw(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b010, 5'(rd), 7'h03};
    endfunction

    task automatic check_bundle(input bit all);
        chk("ex_valid", 32'(bus.ex_valid), 32'(m_b.v));
        if (all || m_b.v) begin
            chk("ex_pc", bus.ex_pc, m_b.pc);
            chk("ex_rs1_data", bus.ex_rs1_data, m_b.a);
            chk("ex_rs2_data", bus.ex_rs2_data, m_b.b);
            chk("ex_imm", bus.ex_imm, m_b.imm);
            chk("ex_rd", 32'(bus.ex_rd), 32'(m_b.rd));
            chk("ex_rd_we", 32'(bus.ex_rd_we), 32'(m_b.we));
            chk("ex_opcode", 32'(bus.ex_opcode), 32'(m_b.op));
            chk("ex_funct3", 32'(bus.ex_funct3), 32'(m_b.f3));
            chk("ex_funct7b5", 32'(bus.ex_funct7b5), 32'(m_b.f7));
            chk("ex_illegal", 32'(bus.ex_illegal), 32'(m_b.ill));
        end
    endtask

    // One clock: drive at edge+1, check combinational outputs at edge+3, advance model and DUT.
    task automatic cyc(input bit v, input logic [31:0] ins, input logic [31:0] pc,
                       input bit wbe, input logic [4:0] wbi, input logic [31:0] wbd,
                       input bit fl, input bit er, output bit rdy);
        dec_t        d;
        logic [4:0]  rd, rs1, rs2;
        bit          haz, exp_rdy, issue;
        logic [31:0] np;
        bundle_t     nb;
        bus.if_valid      = v;
        bus.if_instr      = ins;
        bus.if_pc         = pc;
        bus.wb_en         = wbe;
        bus.wb_id         = wbi;
        bus.wb_data       = wbd;
        bus.flush         = fl;
        bus.ex_ready      = er;
        bus.rf_read1_data = rf[ins[19:15]];
        bus.rf_read2_data = rf[ins[24:20]];
        #2;
        d   = ref_dec(ins);
        rd  = ins[11:7];
        rs1 = ins[19:15];
        rs2 = ins[24:20];
        haz = (d.u1 && busy_ref(rs1, wbe, wbi)) || (d.u2 && busy_ref(rs2, wbe, wbi)) ||
              (d.we && busy_ref(rd, wbe, wbi));
        exp_rdy = (!m_b.v || er) && !haz && !fl;
        issue   = v && exp_rdy;
        chk("rf_read1_id", 32'(bus.rf_read1_id), 32'(rs1));
        chk("rf_read2_id", 32'(bus.rf_read2_id), 32'(rs2));
        chk("if_ready", 32'(bus.if_ready), 32'(exp_rdy));
        rdy = bus.if_ready;
        np = m_pend;
        if (wbe && wbi != 0) np[wbi] = 1'b0;
        if (fl && m_b.v && !er && m_b.we) np[m_b.rd] = 1'b0;
        if (issue && d.we) np[rd] = 1'b1;
        nb = m_b;
        if (issue) begin
            nb.v   = 1;
            nb.pc  = pc;
            nb.a   = opnd_ref(rs1, wbe, wbi, wbd);
            nb.b   = opnd_ref(rs2, wbe, wbi, wbd);
            nb.imm = d.imm;
            nb.rd  = rd;
            nb.we  = d.we;
            nb.op  = ins[6:0];
            nb.f3  = ins[14:12];
            nb.f7  = ins[30];
            nb.ill = d.ill;
        end else if (er || fl) begin
            nb.v = 0;
        end
        @(posedge clk);
        #1;
        m_pend = np;
        m_b    = nb;
        check_bundle(1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r;
        logic [31:0] ins;
        logic [6:0]  op;
        int          sel;
        rst_n = 1'b0;
        bus.if_valid = 0; bus.if_instr = 0; bus.if_pc = 0;
        bus.rf_read1_data = 0; bus.rf_read2_data = 0;
        bus.wb_en = 0; bus.wb_id = 0; bus.wb_data = 0; bus.flush = 0; bus.ex_ready = 0;
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        m_pend = '0;
        m_b    = '0;
        @(posedge clk);
        #1;
        check_bundle(1'b1);
        chk("reset_if_ready", 32'(bus.if_ready), 32'd1);
        rst_n = 1'b1;

        // Independent issue back to back.
        cyc(1, addi(1, 0, 5), 32'h100, 0, 0, 0, 0, 1, r);
        chk("t1_rdy", 32'(r), 1); chk("t1_rd", 32'(bus.ex_rd), 1); chk("t1_imm", bus.ex_imm, 5);
        cyc(1, addi(2, 0, -1), 32'h104, 0, 0, 0, 0, 1, r);
        chk("t2_rdy", 32'(r), 1); chk("t2_rd", 32'(bus.ex_rd), 2);
        chk("t2_imm", bus.ex_imm, 32'hFFFF_FFFF);
        cyc(0, 0, 0, 1, 1, 0, 0, 1, r);
        cyc(0, 0, 0, 1, 2, 0, 0, 1, r);

        // RAW stall resolved by bypass.
        rf[5] = 32'h0;
        cyc(1, addi(5, 0, 7), 32'h108, 0, 0, 0, 0, 1, r);
        cyc(1, add(6, 5, 5), 32'h10C, 0, 0, 0, 0, 1, r);
        chk("raw_stall", 32'(r), 0);
        cyc(1, add(6, 5, 5), 32'h10C, 1, 5, 7, 0, 1, r);
        chk("raw_issue", 32'(r), 1);
        chk("raw_rs1", bus.ex_rs1_data, 7); chk("raw_rs2", bus.ex_rs2_data, 7);
        cyc(0, 0, 0, 1, 6, 0, 0, 1, r);

        // Backpressure holds the bundle, drains on first ready.
        cyc(1, addi(10, 0, 9), 32'h200, 0, 0, 0, 0, 1, r);
        for (int k = 0; k < 3; k++) begin
            cyc(1, addi(11, 0, 1), 32'h204, 0, 0, 0, 0, 0, r);
            chk("bp_rdy", 32'(r), 0); chk("bp_imm", bus.ex_imm, 9);
        end
        cyc(1, addi(11, 0, 1), 32'h204, 0, 0, 0, 0, 1, r);
        chk("bp_drain", 32'(r), 1); chk("bp_rd", 32'(bus.ex_rd), 11);

        // Flush of a held writer releases its scoreboard bit.
        cyc(1, lw(8, 0, 16), 32'h300, 0, 0, 0, 0, 1, r);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, r);
        cyc(1, add(9, 8, 0), 32'h304, 0, 0, 0, 1, 0, r);
        chk("flush_rdy", 32'(r), 0); chk("flush_valid", 32'(bus.ex_valid), 0);
        cyc(1, add(9, 8, 0), 32'h304, 0, 0, 0, 0, 1, r);
        chk("flush_nostall", 32'(r), 1); chk("flush_rd", 32'(bus.ex_rd), 9);

        // x0 never written, never bypassed.
        rf[0] = 32'h1234;
        cyc(1, addi(0, 0, 3), 32'h400, 0, 0, 0, 0, 1, r);
        chk("x0_we", 32'(bus.ex_rd_we), 0);
        cyc(1, add(12, 0, 0), 32'h404, 1, 0, 32'hDEAD, 0, 1, r);
        chk("x0_rdy", 32'(r), 1);
        chk("x0_rs1", bus.ex_rs1_data, 0); chk("x0_rs2", bus.ex_rs2_data, 0);

        // Illegal opcode.
        cyc(1, 32'h00A0_05FF, 32'h408, 0, 0, 0, 0, 1, r);
        chk("ill_flag", 32'(bus.ex_illegal), 1); chk("ill_we", 32'(bus.ex_rd_we), 0);

        // Async reset in the middle of a stall.
        cyc(1, addi(13, 0, 1), 32'h500, 0, 0, 0, 0, 1, r);
        cyc(1, add(14, 13, 0), 32'h504, 0, 0, 0, 0, 1, r);
        chk("rst_stall", 32'(r), 0);
        #2;
        rst_n = 1'b0;
        #1;
        m_pend = '0;
        m_b    = '0;
        chk("rst_async_valid", 32'(bus.ex_valid), 0);
        chk("rst_async_ready", 32'(bus.if_ready), 1);
        chk("rst_async_rd", 32'(bus.ex_rd), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Random traffic over a small register window to provoke hazards.
        for (int k = 0; k < 400; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = 7'h37;
                1: op = 7'h17;
                2: op = 7'h6F;
                3: op = 7'h67;
                4: op = 7'h63;
                5: op = 7'h03;
                6: op = 7'h23;
                7: op = 7'h13;
                8: op = 7'h33;
                default: op = ($urandom_range(0, 1) == 1) ? 7'h7F : 7'h0F;
            endcase
            ins = $urandom;
            ins[6:0]   = op;
            ins[11:7]  = 5'($urandom_range(0, 7));
            ins[19:15] = 5'($urandom_range(0, 7));
            ins[24:20] = 5'($urandom_range(0, 7));
            rf[$urandom_range(1, 31)] = $urandom;
            cyc(($urandom_range(0, 3) != 0), ins, $urandom, ($urandom_range(0, 1) == 1),
                5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 15) == 0),
                ($urandom_range(0, 3) != 0), r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
Decode/operand-fetch stage between instruction fetch and execute. Decodes one RV32I instruction per cycle and drives the register file read ports. Applies write-back bypass and a pending-write scoreboard to stall on RAW/WAW hazards, then registers the decoded bundle to execute over a valid/ready handshake.

Parameters:
XLEN, 32, datapath width of pc, operands and immediate.
NREGS, 32, number of architectural registers; ids are 5 bits.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
if_valid  in  1  fetch offers instruction
if_ready  out  1  stage accepts instruction this cycle (combinational)
if_instr  in  32  instruction word
if_pc  in  XLEN  instruction address
rf_read1_id  out  5  = if_instr[19:15], combinational
rf_read2_id  out  5  = if_instr[24:20], combinational
rf_read1_data  in  XLEN  register file port 1 data (combinational read)
rf_read2_data  in  XLEN  register file port 2 data
wb_en  in  1  write-back strobe; same signal as the register file write enable
wb_id  in  5  write-back register id
wb_data  in  XLEN  write-back data
flush  in  1  kill held and incoming instruction
ex_valid  out  1  bundle valid
ex_ready  in  1  execute accepts bundle
ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered bundle fields
ex_rd  out  5  destination id
ex_rd_we  out  1  destination write enable
ex_opcode  out  7; ex_funct3  out  3; ex_funct7b5  out  1  (instr[30])
ex_illegal  out  1  unsupported opcode

Behaviour:
- Reset (rst_n=0, async): ex_valid=0, all ex_* fields=0, scoreboard=0. Out of reset, if_ready=1 (subject to ex_ready/flush).
- Opcodes supported: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP. Any other opcode: ex_illegal=1, ex_rd_we=0, no source use.
- rs1 used by JALR/BRANCH/LOAD/STORE/OP-IMM/OP. rs2 used by BRANCH/STORE/OP.
- ex_rd_we=1 only for LUI/AUIPC/JAL/JALR/LOAD/OP-IMM/OP with rd!=0.
- Immediates are I/S/B/U/J formats, sign-extended to XLEN; 0 for OP.
- Operand data: a source id of 0 yields 0. Otherwise, if wb_en && wb_id==src, the operand is wb_data (bypass). Otherwise it is rf_readN_data.
- Scoreboard: NREGS pending bits; bit 0 is never set.
  - A register is busy if its bit is set and not (wb_en && wb_id==reg) this cycle.
- hazard = (rs1 used && busy(rs1)) || (rs2 used && busy(rs2)) || (rd_we && busy(rd)). The last term is the WAW stall.
- if_ready = (!ex_valid || ex_ready) && !hazard && !flush.
- Issue: if_valid && if_ready. The bundle is registered next edge with ex_valid=1, and pending[rd] is set if rd_we.
  - A same-cycle wb clear of the same id loses to the set.
- wb_en && wb_id!=0 clears pending[wb_id] when no issue sets that bit.
- Stall or no input with ex_ready=1: ex_valid drops to 0 next edge.
  - With ex_ready=0, all ex_* outputs hold stable.
- Flush: ex_valid=0 next edge and no issue this cycle.
  - If ex_valid && !ex_ready && ex_rd_we in the flush cycle, the held instruction is killed and pending[ex_rd] is cleared.
  - If ex_valid && ex_ready in the flush cycle, the bundle counts as delivered and its pending bit remains.
  - A wb_en in the flush cycle is still honoured.
- Latency: accepted instruction appears on ex_* exactly 1 cycle later; throughput 1 per cycle absent hazards.
- Reset asserted mid-stall or mid-flush returns all state to reset values immediately.

Test Plan:
- Independent issue: addi x1,x0,5 then addi x2,x0,-1, ex_ready=1 -> consecutive cycles ex_rd=1, ex_imm=5; then ex_rd=2, ex_imm=0xFFFFFFFF. if_ready stays 1.
- RAW stall and bypass: addi x5,x0,7 then add x6,x5,x5.
  - Second instruction: if_ready=0 until a cycle with wb_en=1, wb_id=5, wb_data=7.
  - In that cycle it issues with ex_rs1_data=ex_rs2_data=7 while rf data still reads 0.
- Backpressure: ex_ready=0 for 3 cycles with bundle held -> ex_* bit-stable and if_ready=0. The bundle drains on the first cycle ex_ready=1.
- Flush of held writer: issue lw x8 while ex_ready=0, then assert flush -> ex_valid=0 next cycle. A following add x9,x8,x0 issues with no stall.
- x0 handling: addi x0,x0,3 -> ex_rd_we=0. A later reader of x0, with wb_en=1, wb_id=0, wb_data=0xDEAD, gets operand 0 with no stall.
- Illegal opcode 0x7F -> ex_illegal=1, ex_rd_we=0.
- Async reset mid-stall -> ex_valid=0 and scoreboard cleared without waiting for a clock edge.
